xadc_multi_sampler: RTL and testbench

//  Parametrised multi-channel XADC sampler, successor to the single-channel LED meter. Sequences DRP reads

---
 rtl/xadc_multi_sampler_if.sv | 9 +
 rtl/xadc_multi_sampler.sv | 123 ++++++++++++
 tb/tb_xadc_multi_sampler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_multi_sampler_if.sv
// xadc_multi_sampler_if: DRP read port between the sampler (master) and the XADC wizard (slave).
interface xadc_multi_sampler_if;
    logic [6:0]  daddr;
    logic        den;
    logic [15:0] do_in;
    logic        drdy;
    modport master (output daddr, den, input do_in, drdy);
    modport slave (input daddr, den, output do_in, drdy);
endinterface

// File: rtl/xadc_multi_sampler.sv
// xadc_multi_sampler: scans NUM_CH XADC aux channels over DRP, box-car averages 2^AVG_LOG2 reads each,
// stores one result per channel and shows the selected channel as a level code and thermometer bar.
module xadc_multi_sampler #(
    parameter int         NUM_CH     = 4,
    parameter logic [6:0] CH_BASE    = 7'h16,
    parameter int         AVG_LOG2   = 2,
    parameter int         SAMPLE_DIV = 1000,
    parameter int         TIMEOUT    = 255,
    parameter int         BAR_W      = 16,
    localparam int        LEVEL_BITS = $clog2(BAR_W),
    localparam int        SW         = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                  CLK100MHZ,
    input  logic                  RST,
    xadc_multi_sampler_if.master  drp,
    input  logic [SW-1:0]         sel,
    output logic [11:0]           result,
    output logic [SW-1:0]         res_ch,
    output logic                  res_valid,
    output logic [LEVEL_BITS-1:0] level,
    output logic [BAR_W-1:0]      bar,
    output logic                  timeout_err
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int DW = SAMPLE_DIV > 2 ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, PUB} state_t;

    state_t          state;
    logic [DW-1:0]   div;
    logic [SW-1:0]   ch;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [TW-1:0]   timer;
    // Sized to the full sel range so out-of-range selections read a never-written zero entry.
    logic [11:0]     store [2**SW];

    logic                  tick;
    logic                  last;
    logic [AW-1:0]         acc_n;
    logic [11:0]           avg;
    logic [SW-1:0]         ch_n;
    logic [LEVEL_BITS-1:0] lvl_n;
    logic [BAR_W-1:0]      bar_n;
    logic                  unused_lsb;

    assign tick       = div == DW'(SAMPLE_DIV - 1);
    assign last       = cnt == CW'((1 << AVG_LOG2) - 1);
    assign acc_n      = acc + AW'(drp.do_in[15:4]);
    assign avg        = 12'(acc_n >> AVG_LOG2);
    assign ch_n       = 32'(ch) == NUM_CH - 1 ? '0 : ch + 1'b1;
    assign lvl_n      = store[sel][11 -: LEVEL_BITS];
    assign unused_lsb = ^drp.do_in[3:0];

    always_comb begin
        bar_n = '0;
        for (int i = 0; i < BAR_W; i++) bar_n[i] = i <= 32'(lvl_n);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state       <= IDLE;
            div         <= '0;
            ch          <= '0;
            cnt         <= '0;
            acc         <= '0;
            timer       <= '0;
            drp.daddr   <= CH_BASE;
            drp.den     <= 1'b0;
            result      <= '0;
            res_ch      <= '0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
            level       <= '0;
            bar         <= BAR_W'(1);
            for (int i = 0; i < 2**SW; i++) store[i] <= '0;
        end else begin
            div       <= tick ? '0 : div + 1'b1;
            level     <= lvl_n;
            bar       <= bar_n;
            drp.den   <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    state     <= REQ;
                    drp.den   <= 1'b1;
                    drp.daddr <= CH_BASE + 7'(ch);
                end
                REQ: begin
                    state <= WAIT;
                    timer <= '0;
                end
                WAIT: if (drp.drdy) begin
                    acc   <= acc_n;
                    cnt   <= cnt + 1'b1;
                    state <= last ? PUB : IDLE;
                    if (last) begin
                        result    <= avg;
                        res_ch    <= ch;
                        res_valid <= 1'b1;
                        store[ch] <= avg;
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                    ch          <= ch_n;
                    state       <= IDLE;
                end else begin
                    timer <= timer + 1'b1;
                end
                PUB: begin
                    acc   <= '0;
                    cnt   <= '0;
                    ch    <= ch_n;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xadc_multi_sampler.sv
// tb_xadc_multi_sampler: randomized DRP responder with a per-set averaging model and per-cycle compare.
module tb_xadc_multi_sampler;
    localparam int         NUM_CH     = 4;
    localparam logic [6:0] CH_BASE    = 7'h16;
    localparam int         AVG_LOG2   = 2;
    localparam int         SAMPLE_DIV = 40;
    localparam int         TIMEOUT    = 20;
    localparam int         BAR_W      = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = '0;
    logic [11:0] result;
    logic [1:0]  res_ch;
    logic        res_valid;
    logic [3:0]  level;
    logic [15:0] bar;
    logic        timeout_err;

    xadc_multi_sampler_if drp();

    xadc_multi_sampler #(
        .NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .AVG_LOG2(AVG_LOG2),
        .SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT), .BAR_W(BAR_W)
    ) dut (
        .CLK100MHZ(clk), .RST(rst), .drp(drp), .sel(sel), .result(result), .res_ch(res_ch),
        .res_valid(res_valid), .level(level), .bar(bar), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int lvl_of(int v);
        return v >> 8;
    endfunction

    function automatic logic [15:0] bar_of(int l);
        return 16'((1 << (l + 1)) - 1);
    endfunction

    typedef struct {int cyc; int ch; int res;} exp_t;
    exp_t q[$];
    int   m_ch = 0, m_cnt = 0, m_sum = 0, err_cycle = 0, pend_lvl = 0;
    int   store_m[NUM_CH] = '{default: 0};
    int   seq2[4] = '{100, 101, 102, 104};
    int   data_mode = 1;
    logic [15:0] fix_data = 16'h8000;
    bit   seq2_en = 0, withhold1 = 0, long_delay = 0, resp_stale = 0, hold = 1;
    int   resp_cnt = 0;
    logic [15:0] resp_data = '0;

    // DRP slave plus model: every completed set of 4 reads yields one expected strobe one clock after its last drdy.
    initial begin
        drp.drdy  = 1'b0;
        drp.do_in = '0;
        forever begin
            @(posedge clk);
            #1;
            drp.drdy  = 1'b0;
            drp.do_in = 16'($urandom);
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    drp.drdy  = 1'b1;
                    drp.do_in = resp_data;
                    if (resp_stale) resp_stale = 0;
                    else begin
                        m_sum += int'(resp_data[15:4]);
                        m_cnt++;
                        if (m_cnt == (1 << AVG_LOG2)) begin
                            q.push_back('{cyc + 1, m_ch, m_sum >> AVG_LOG2});
                            m_sum = 0;
                            m_cnt = 0;
                            m_ch  = (m_ch + 1) % NUM_CH;
                        end
                    end
                end
            end
            if (drp.den && !hold) begin
                check("daddr_at_den", 32'(drp.daddr), 32'(CH_BASE) + 32'(m_ch));
                if (withhold1 && m_ch == 1) begin
                    withhold1 = 0;
                    if (err_cycle == 0) err_cycle = cyc + TIMEOUT + 1;
                    m_sum = 0;
                    m_cnt = 0;
                    m_ch  = (m_ch + 1) % NUM_CH;
                end else begin
                    resp_data = data_mode == 1 ? fix_data : 16'($urandom);
                    if (seq2_en && m_ch == 2) resp_data = {12'(seq2[m_cnt]), 4'h0};
                    resp_cnt = long_delay ? 10 : $urandom_range(1, 6);
                end
            end
        end
    end

    int   last_den = -1;
    logic [6:0] last_addr = '0;
    bit   addr_valid = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (hold) begin
                last_den   = -1;
                addr_valid = 0;
                continue;
            end
            begin
                bit   expv;
                exp_t e;
                expv = q.size() > 0 && q[0].cyc == cyc;
                check("res_valid", 32'(res_valid), 32'(expv));
                if (expv) begin
                    e = q.pop_front();
                    check("res_ch", 32'(res_ch), e.ch);
                    check("result", 32'(result), e.res);
                    store_m[e.ch] = e.res;
                end
            end
            check("level", 32'(level), pend_lvl);
            check("bar", 32'(bar), 32'(bar_of(pend_lvl)));
            check("timeout_err", 32'(timeout_err), 32'(err_cycle != 0 && cyc >= err_cycle));
            if (last_den >= 0 && last_den == cyc - 1) check("den_width", 32'(drp.den), 0);
            if (drp.den) begin
                if (last_den >= 0) check("den_period", cyc - last_den, SAMPLE_DIV);
                last_den   = cyc;
                last_addr  = drp.daddr;
                addr_valid = 1;
            end else if (addr_valid) begin
                check("daddr_hold", 32'(drp.daddr), 32'(last_addr));
            end
            pend_lvl = lvl_of(store_m[sel]);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        hold       = 1;
        resp_stale = resp_cnt > 0;
        q.delete();
        m_ch = 0; m_cnt = 0; m_sum = 0; err_cycle = 0; pend_lvl = 0;
        withhold1 = 0;
        foreach (store_m[i]) store_m[i] = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_daddr", 32'(drp.daddr), 32'h16);
        check("rst_den", 32'(drp.den), 0);
        check("rst_result", 32'(result), 0);
        check("rst_res_ch", 32'(res_ch), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_bar", 32'(bar), 32'h0001);
        check("rst_timeout_err", 32'(timeout_err), 0);
        rst  = 1'b0;
        hold = 0;
    endtask

    task automatic wait_strobe(output int ch, output int res);
        ch  = -1;
        res = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) begin
                ch  = int'(res_ch);
                res = int'(result);
                return;
            end
        end
        n_chk++;
        $display("FAIL strobe_wait: no res_valid within 3000 cycles (cycle %0d)", cyc);
    endtask

    task automatic wait_den();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (drp.den) return;
        end
        n_chk++;
        $display("FAIL den_wait: no den within 200 cycles (cycle %0d)", cyc);
    endtask

    task automatic set_sel(logic [1:0] v);
        @(posedge clk);
        #3;
        sel = v;
    endtask

    initial begin
        int ch, res;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wait_strobe(ch, res);
            check("t1_ch", ch, k % 4);
            check("t1_res", res, 32'h800);
        end
        set_sel(2'd1);
        repeat (2) @(negedge clk);
        #1;
        check("t1_level", 32'(level), 8);
        check("t1_bar", 32'(bar), 32'h01FF);

        do_reset();
        data_mode = 0;
        seq2_en   = 1;
        for (int k = 0; k < 3; k++) wait_strobe(ch, res);
        check("t2_ch", ch, 2);
        check("t2_res", res, 101);
        seq2_en = 0;

        do_reset();
        withhold1 = 1;
        wait_strobe(ch, res);
        check("t3_first_ch", ch, 0);
        wait_strobe(ch, res);
        check("t3_next_ch", ch, 2);
        check("t3_err", 32'(timeout_err), 1);

        do_reset();
        data_mode = 1;
        fix_data  = 16'hFFF0;
        set_sel(2'd0);
        wait_strobe(ch, res);
        check("t4_res", res, 32'hFFF);
        fix_data = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        check("t4_level", 32'(level), 15);
        check("t4_bar", 32'(bar), 32'hFFFF);
        for (int k = 0; k < 4; k++) wait_strobe(ch, res);
        check("t4_zero_ch", ch, 0);
        check("t4_zero_res", res, 0);
        repeat (2) @(negedge clk);
        #1;
        check("t4_zero_bar", 32'(bar), 32'h0001);

        do_reset();
        data_mode  = 0;
        long_delay = 1;
        wait_den();
        repeat (2) @(posedge clk);
        do_reset();
        long_delay = 0;
        wait_den();
        check("t5_daddr", 32'(drp.daddr), 32'h16);
        wait_strobe(ch, res);
        check("t5_ch", ch, 0);

        for (int k = 0; k < 12; k++) begin
            wait_strobe(ch, res);
            set_sel(2'($urandom));
            if (k == 5) withhold1 = 1;
        end
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
